// File: rtl/jesd204b_dl_rx.sv
// rtl/jesd204b_dl_rx.sv - JESD204B single-lane data link layer receiver
//
// Purpose:
//   Receive-side data link layer for one JESD204B lane. Performs code group
//   synchronisation (CGS), checks the initial lane alignment sequence (ILAS)
//   and captures its 14 configuration octets, then tracks frame/multiframe
//   alignment in the user-data phase and undoes /F/ and /A/ character
//   replacement when the link is not scrambled.
//
// Ports:
//   clk             in   1    clock
//   reset           in   1    synchronous, active-high
//   in              in   32   lane word, octet 0 (earliest) in [7:0]
//   ctrl_in         in   4    bit i set = octet i is a K character
//   scramble_enable in   1    1 = scrambled link, replacement undo disabled
//   sync_request    out  1    1 = request CGS (SYNC~ asserted)
//   out             out  32   recovered user data
//   out_valid       out  1    out carries user data
//   eof_out         out  4    bit i = octet i of out ends a frame
//   eom_out         out  4    bit i = octet i of out ends a multiframe
//   config_out      out  112  ILAS config octets, octet k at [8k+:8]
//   config_valid    out  1    config_out taken from a good ILAS
//   link_state      out  2    0 CGS_SYNC, 1 CGS_WAIT, 2 ILAS, 3 DATA
//   ilas_error      out  1    one-cycle pulse on ILAS check failure
//   kchar_error     out  1    one-cycle pulse on unexpected K in DATA

module jesd204b_dl_rx #(
  parameter int OCTETS_PER_FR = 5,
  parameter int FRAMES_PER_MF = 4,
  parameter int K_WORDS       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in,
  input  logic [3:0]   ctrl_in,
  input  logic         scramble_enable,
  output logic         sync_request,
  output logic [31:0]  out,
  output logic         out_valid,
  output logic [3:0]   eof_out,
  output logic [3:0]   eom_out,
  output logic [111:0] config_out,
  output logic         config_valid,
  output logic [1:0]   link_state,
  output logic         ilas_error,
  output logic         kchar_error
);

  // Words per multiframe; at least 5 given the legal F*K range.
  localparam int MFW = (OCTETS_PER_FR * FRAMES_PER_MF) / 4;
  localparam int WMW = $clog2(MFW);
  localparam int KCW = (K_WORDS > 1) ? $clog2(K_WORDS) : 1;
  localparam int FPW = (OCTETS_PER_FR > 1) ? $clog2(OCTETS_PER_FR) : 1;

  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_A = 8'h7C;
  localparam logic [7:0] K_Q = 8'h9C;
  localparam logic [7:0] K_F = 8'hFC;

  typedef enum logic [1:0] {
    ST_CGS_SYNC = 2'd0,
    ST_CGS_WAIT = 2'd1,
    ST_ILAS     = 2'd2,
    ST_DATA     = 2'd3
  } state_t;

  state_t         r_state;
  logic [KCW-1:0] r_kcnt;
  logic [1:0]     r_mf;      // ILAS multiframe index
  logic [WMW-1:0] r_wm;      // word index inside the current multiframe
  logic [FPW-1:0] r_fpos;    // octet position inside the frame at word start
  logic [7:0]     r_prev;    // last output octet of the previous frame
  logic           r_sync;
  logic [31:0]    r_out;
  logic           r_out_valid;
  logic [3:0]     r_eof;
  logic [3:0]     r_eom;
  logic [111:0]   r_cfg;
  logic           r_cfg_valid;
  logic           r_ilas_err;
  logic           r_kchar_err;

  state_t         w_nxt_state;
  logic [KCW-1:0] w_nxt_kcnt;
  logic [1:0]     w_nxt_mf;
  logic [WMW-1:0] w_nxt_wm;
  logic [FPW-1:0] w_nxt_fpos;
  logic [7:0]     w_nxt_prev;
  logic           w_nxt_sync;
  logic [31:0]    w_nxt_out;
  logic           w_nxt_out_valid;
  logic [3:0]     w_nxt_eof;
  logic [3:0]     w_nxt_eom;
  logic [111:0]   w_nxt_cfg;
  logic           w_nxt_cfg_valid;
  logic           w_nxt_ilas_err;
  logic           w_nxt_kchar_err;

  logic           w_all_k;
  logic           w_mf_last;

  // ILAS word check and config capture
  logic           w_ilas_ok;
  logic [111:0]   w_ilas_cfg;
  int             w_ipos;

  // DATA path: replacement undo and frame tracking
  logic [31:0]    w_dout;
  logic [3:0]     w_deof;
  logic [3:0]     w_deom;
  logic           w_dkerr;
  logic [7:0]     w_dprev;
  int             w_dfp;
  logic [7:0]     w_doct;
  logic [7:0]     w_dres;
  logic           w_eof_i;
  logic           w_eom_i;

  assign w_all_k   = (in == 32'hBCBC_BCBC) && (ctrl_in == 4'hF);
  assign w_mf_last = (r_wm == WMW'(MFW - 1));

  // Every ILAS octet has exactly one allowed K value; control octets also
  // have a fixed code. r_mf/r_wm are zero in CGS_WAIT so the /R/ word that
  // ends CGS is checked as ILAS word 0.
  always_comb begin
    w_ilas_ok  = 1'b1;
    w_ilas_cfg = r_cfg;
    w_ipos     = 0;
    for (int i = 0; i < 4; i++) begin
      w_ipos = 4 * int'(r_wm) + i;
      if (w_ipos == 0) begin
        w_ilas_ok = w_ilas_ok && ctrl_in[i] && (in[8*i +: 8] == K_R);
      end else if (w_ipos == 4 * MFW - 1) begin
        w_ilas_ok = w_ilas_ok && ctrl_in[i] && (in[8*i +: 8] == K_A);
      end else if (r_mf == 2'd1 && w_ipos == 1) begin
        w_ilas_ok = w_ilas_ok && ctrl_in[i] && (in[8*i +: 8] == K_Q);
      end else begin
        w_ilas_ok = w_ilas_ok && !ctrl_in[i];
      end
      if (r_mf == 2'd1 && w_ipos >= 2 && w_ipos <= 15) begin
        w_ilas_cfg[8*(w_ipos-2) +: 8] = in[8*i +: 8];
      end
    end
  end

  // Octets are walked in arrival order so an eof early in the word updates
  // the replacement source for a later eof in the same word (F < 4).
  always_comb begin
    w_dout  = 32'h0;
    w_deof  = 4'h0;
    w_deom  = 4'h0;
    w_dkerr = 1'b0;
    w_dprev = r_prev;
    w_dfp   = int'(r_fpos);
    w_doct  = 8'h00;
    w_dres  = 8'h00;
    w_eof_i = 1'b0;
    w_eom_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_doct  = in[8*i +: 8];
      w_dres  = w_doct;
      w_eof_i = (w_dfp == OCTETS_PER_FR - 1);
      w_eom_i = (i == 3) && w_mf_last;
      if (ctrl_in[i]) begin
        if ((w_eof_i && w_doct == K_F) || (w_eom_i && w_doct == K_A)) begin
          if (!scramble_enable) begin
            w_dres = w_dprev;
          end
        end else begin
          w_dkerr = 1'b1;
        end
      end
      if (w_eof_i) begin
        w_dprev = w_dres;
      end
      w_dfp          = w_eof_i ? 0 : w_dfp + 1;
      w_dout[8*i +: 8] = w_dres;
      w_deof[i]      = w_eof_i;
      w_deom[i]      = w_eom_i;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_kcnt      = '0;
    w_nxt_mf        = 2'd0;
    w_nxt_wm        = '0;
    w_nxt_fpos      = '0;
    w_nxt_prev      = r_prev;
    w_nxt_sync      = r_sync;
    w_nxt_out       = 32'h0;
    w_nxt_out_valid = 1'b0;
    w_nxt_eof       = 4'h0;
    w_nxt_eom       = 4'h0;
    w_nxt_cfg       = r_cfg;
    w_nxt_cfg_valid = r_cfg_valid;
    w_nxt_ilas_err  = 1'b0;
    w_nxt_kchar_err = 1'b0;

    case (r_state)
      ST_CGS_SYNC: begin
        w_nxt_sync = 1'b1;
        if (w_all_k) begin
          if (int'(r_kcnt) + 1 >= K_WORDS) begin
            w_nxt_state = ST_CGS_WAIT;
            w_nxt_sync  = 1'b0;
          end else begin
            w_nxt_kcnt = KCW'(int'(r_kcnt) + 1);
          end
        end
      end

      ST_CGS_WAIT: begin
        if (w_all_k) begin
          w_nxt_state = ST_CGS_WAIT;
        end else if (ctrl_in[0] && in[7:0] == K_R) begin
          if (w_ilas_ok) begin
            w_nxt_state = ST_ILAS;
            w_nxt_wm    = WMW'(1);
          end else begin
            w_nxt_state     = ST_CGS_SYNC;
            w_nxt_sync      = 1'b1;
            w_nxt_cfg_valid = 1'b0;
            w_nxt_ilas_err  = 1'b1;
          end
        end else begin
          w_nxt_state = ST_CGS_SYNC;
          w_nxt_sync  = 1'b1;
        end
      end

      ST_ILAS: begin
        if (!w_ilas_ok) begin
          w_nxt_state     = ST_CGS_SYNC;
          w_nxt_sync      = 1'b1;
          w_nxt_cfg_valid = 1'b0;
          w_nxt_ilas_err  = 1'b1;
        end else begin
          w_nxt_cfg = w_ilas_cfg;
          if (w_mf_last && r_mf == 2'd3) begin
            w_nxt_state     = ST_DATA;
            w_nxt_cfg_valid = 1'b1;
            w_nxt_prev      = 8'h00;
          end else if (w_mf_last) begin
            w_nxt_mf = r_mf + 2'd1;
          end else begin
            w_nxt_mf = r_mf;
            w_nxt_wm = r_wm + WMW'(1);
          end
        end
      end

      ST_DATA: begin
        if (w_all_k) begin
          // Transmitter has gone back to CGS.
          w_nxt_state = ST_CGS_SYNC;
          w_nxt_sync  = 1'b1;
        end else begin
          w_nxt_out       = w_dout;
          w_nxt_out_valid = 1'b1;
          w_nxt_eof       = w_deof;
          w_nxt_eom       = w_deom;
          w_nxt_kchar_err = w_dkerr;
          w_nxt_prev      = w_dprev;
          w_nxt_fpos      = FPW'(w_dfp);
          w_nxt_wm        = w_mf_last ? '0 : r_wm + WMW'(1);
        end
      end

      default: begin
        w_nxt_state = ST_CGS_SYNC;
        w_nxt_sync  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CGS_SYNC;
      r_kcnt      <= '0;
      r_mf        <= 2'd0;
      r_wm        <= '0;
      r_fpos      <= '0;
      r_prev      <= 8'h00;
      r_sync      <= 1'b1;
      r_out       <= 32'h0;
      r_out_valid <= 1'b0;
      r_eof       <= 4'h0;
      r_eom       <= 4'h0;
      r_cfg       <= 112'h0;
      r_cfg_valid <= 1'b0;
      r_ilas_err  <= 1'b0;
      r_kchar_err <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_kcnt      <= w_nxt_kcnt;
      r_mf        <= w_nxt_mf;
      r_wm        <= w_nxt_wm;
      r_fpos      <= w_nxt_fpos;
      r_prev      <= w_nxt_prev;
      r_sync      <= w_nxt_sync;
      r_out       <= w_nxt_out;
      r_out_valid <= w_nxt_out_valid;
      r_eof       <= w_nxt_eof;
      r_eom       <= w_nxt_eom;
      r_cfg       <= w_nxt_cfg;
      r_cfg_valid <= w_nxt_cfg_valid;
      r_ilas_err  <= w_nxt_ilas_err;
      r_kchar_err <= w_nxt_kchar_err;
    end
  end

  assign sync_request = r_sync;
  assign out          = r_out;
  assign out_valid    = r_out_valid;
  assign eof_out      = r_eof;
  assign eom_out      = r_eom;
  assign config_out   = r_cfg;
  assign config_valid = r_cfg_valid;
  assign link_state   = r_state;
  assign ilas_error   = r_ilas_err;
  assign kchar_error  = r_kchar_err;

endmodule
